// File: rtl/ecc_read_corrector.sv
// ecc_read_corrector: read-path SEC-DED correction stage that sits behind the
// syndrome generator. Corrects single-bit data errors, flags and counts
// correctable/uncorrectable words, and issues a scrub write-back of the clean
// word whenever a correctable error is seen.
module ecc_read_corrector #(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_data,
  input  logic [7:0]    i_syndrome,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_data,
  output logic          o_err_corr,
  output logic          o_err_uncorr,
  output logic          o_scrub_req,
  output logic [AW-1:0] o_scrub_addr,
  output logic [31:0]   o_scrub_data,
  input  logic          i_scrub_ack,
  input  logic          i_count_clr,
  output logic [CW-1:0] o_corr_count,
  output logic [CW-1:0] o_uncorr_count
);

  typedef enum logic {
    IDLE,
    REQ
  } scrub_state_e;

  localparam logic [CW-1:0] COUNT_MAX = '1;

  scrub_state_e state_q;
  scrub_state_e state_d;

  logic [5:0]  syn_pos;
  logic [31:0] flip_mask;
  logic        dec_corr;
  logic        dec_uncorr;
  logic [31:0] dec_data;
  logic        accept;

  // Codeword position of each data bit: data bits fill the non-power-of-two
  // positions 3..38 in ascending order, so each run between check bits is
  // offset by the number of check bits that precede it.
  function automatic logic [5:0] data_pos(input int idx);
    if (idx < 1) begin
      return 6'd3;
    end else if (idx < 4) begin
      return 6'(idx + 4);
    end else if (idx < 11) begin
      return 6'(idx + 5);
    end else if (idx < 26) begin
      return 6'(idx + 6);
    end else begin
      return 6'(idx + 7);
    end
  endfunction

  assign syn_pos = i_syndrome[5:0];

  // Build the one-hot flip mask for the data bit the syndrome points at;
  // check-bit positions and out-of-range positions match no data bit.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < 32; i++) begin
      flip_mask[i] = (syn_pos == data_pos(i));
    end
  end

  // Classify the incoming word. A single error is correctable only when the
  // Hamming position lies inside the 38-bit codeword; every other non-zero
  // syndrome (double error, bad position, syn[7] set) is uncorrectable.
  always_comb begin
    dec_corr   = !i_syndrome[7] && i_syndrome[6] && (syn_pos <= 6'd38);
    dec_uncorr = (i_syndrome != 8'h00) && !dec_corr;
    dec_data   = dec_corr ? (i_data ^ flip_mask) : i_data;
  end

  assign o_ready = (!o_valid || i_ready) && (state_q == IDLE);
  assign accept  = i_valid && o_ready;

  // Output register: load a decoded word on acceptance, drop valid once the
  // consumer has taken it and nothing new replaces it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      o_err_corr   <= 1'b0;
      o_err_uncorr <= 1'b0;
    end else if (accept) begin
      o_valid      <= 1'b1;
      o_addr       <= i_addr;
      o_data       <= dec_data;
      o_err_corr   <= dec_corr;
      o_err_uncorr <= dec_uncorr;
    end else if (i_ready) begin
      o_valid      <= 1'b0;
    end
  end

  // Scrub FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scrub FSM next state: a correctable word opens a request, which stays
  // open until the memory write port acknowledges it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && dec_corr) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_scrub_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scrub FSM outputs: the request is a plain level while in REQ.
  always_comb begin
    o_scrub_req = (state_q == REQ);
  end

  // Capture the scrub address and clean data; acceptance only happens in
  // IDLE, so these stay frozen for the whole time the request is open.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_scrub_addr <= '0;
      o_scrub_data <= '0;
    end else if (accept && dec_corr) begin
      o_scrub_addr <= i_addr;
      o_scrub_data <= dec_data;
    end
  end

  // Correctable-error counter: saturating, clear wins over an increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_corr_count <= '0;
    end else if (i_count_clr) begin
      o_corr_count <= '0;
    end else if (accept && dec_corr && (o_corr_count != COUNT_MAX)) begin
      o_corr_count <= o_corr_count + 1'b1;
    end
  end

  // Uncorrectable-error counter: saturating, clear wins over an increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_uncorr_count <= '0;
    end else if (i_count_clr) begin
      o_uncorr_count <= '0;
    end else if (accept && dec_uncorr && (o_uncorr_count != COUNT_MAX)) begin
      o_uncorr_count <= o_uncorr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_read_corrector.sv
// Bench for ecc_read_corrector: a table of directed words with hand-computed
// results, plus short sequences for scrub stall, backpressure, counter
// saturation/clear and asynchronous reset. A second instance with a 4-bit
// counter shares all inputs so saturation is reachable in a few words.
module tb_ecc_read_corrector;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [7:0]  i_syndrome;
  logic        i_ready;
  logic        i_scrub_ack;
  logic        i_count_clr;

  logic        o_ready,  o_valid,  o_err_corr,  o_err_uncorr,  o_scrub_req;
  logic [31:0] o_addr,   o_data,   o_scrub_addr,  o_scrub_data;
  logic [15:0] o_corr_count, o_uncorr_count;

  logic        o_ready4, o_valid4, o_err_corr4, o_err_uncorr4, o_scrub_req4;
  logic [31:0] o_addr4,  o_data4,  o_scrub_addr4, o_scrub_data4;
  logic [3:0]  o_corr_count4, o_uncorr_count4;

  int n_compared;
  int n_mismatched;
  int model_corr;
  int model_uncorr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  syn;
    logic [31:0] exp_data;
    logic        exp_corr;
    logic        exp_uncorr;
  } vec_t;

  vec_t vecs[17];

  ecc_read_corrector #(.AW(32), .CW(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_data(i_data), .i_syndrome(i_syndrome),
    .o_valid(o_valid), .i_ready(i_ready), .o_addr(o_addr), .o_data(o_data),
    .o_err_corr(o_err_corr), .o_err_uncorr(o_err_uncorr),
    .o_scrub_req(o_scrub_req), .o_scrub_addr(o_scrub_addr),
    .o_scrub_data(o_scrub_data), .i_scrub_ack(i_scrub_ack),
    .i_count_clr(i_count_clr), .o_corr_count(o_corr_count),
    .o_uncorr_count(o_uncorr_count)
  );

  ecc_read_corrector #(.AW(32), .CW(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready4),
    .i_addr(i_addr), .i_data(i_data), .i_syndrome(i_syndrome),
    .o_valid(o_valid4), .i_ready(i_ready), .o_addr(o_addr4), .o_data(o_data4),
    .o_err_corr(o_err_corr4), .o_err_uncorr(o_err_uncorr4),
    .o_scrub_req(o_scrub_req4), .o_scrub_addr(o_scrub_addr4),
    .o_scrub_data(o_scrub_data4), .i_scrub_ack(i_scrub_ack),
    .i_count_clr(i_count_clr), .o_corr_count(o_corr_count4),
    .o_uncorr_count(o_uncorr_count4)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Bounded wait for the stage to accept a word.
  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 20) begin
      step();
      n++;
    end
    if (!o_ready) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL wait_ready: o_ready stuck at 0 after %0d cycles", n);
    end
  endtask

  function automatic logic [63:0] sat4(input int v);
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction

  task automatic check_counts(input string tag);
    check_output({tag, " corr_count"},    64'(o_corr_count),    64'(model_corr));
    check_output({tag, " uncorr_count"},  64'(o_uncorr_count),  64'(model_uncorr));
    check_output({tag, " corr_count4"},   64'(o_corr_count4),   sat4(model_corr));
    check_output({tag, " uncorr_count4"}, 64'(o_uncorr_count4), sat4(model_uncorr));
  endtask

  // Acknowledge an open scrub for one cycle and confirm it closes.
  task automatic ack_scrub(input string tag);
    i_scrub_ack = 1'b1;
    step();
    i_scrub_ack = 1'b0;
    check_output({tag, " scrub_req after ack"}, 64'(o_scrub_req), 64'd0);
  endtask

  // Send one word, then check the registered result, scrub and counters.
  task automatic apply_stimulus(input string tag, input logic [31:0] addr,
                                input logic [31:0] data, input logic [7:0] syn,
                                input logic [31:0] exp_data, input logic exp_corr,
                                input logic exp_uncorr);
    wait_ready();
    i_addr     = addr;
    i_data     = data;
    i_syndrome = syn;
    i_valid    = 1'b1;
    step();
    i_valid = 1'b0;
    if (exp_corr) model_corr++;
    if (exp_uncorr) model_uncorr++;
    check_output({tag, " o_valid"},      64'(o_valid),      64'd1);
    check_output({tag, " o_addr"},       64'(o_addr),       64'(addr));
    check_output({tag, " o_data"},       64'(o_data),       64'(exp_data));
    check_output({tag, " o_err_corr"},   64'(o_err_corr),   64'(exp_corr));
    check_output({tag, " o_err_uncorr"}, 64'(o_err_uncorr), 64'(exp_uncorr));
    check_output({tag, " o_data4"},      64'(o_data4),      64'(exp_data));
    check_output({tag, " o_valid4"},     64'(o_valid4),     64'd1);
    check_output({tag, " o_addr4"},      64'(o_addr4),      64'(addr));
    check_output({tag, " flags4"}, 64'({o_err_corr4, o_err_uncorr4}),
                 64'({exp_corr, exp_uncorr}));
    check_output({tag, " o_scrub_req"},  64'(o_scrub_req),  64'(exp_corr));
    check_output({tag, " o_scrub_req4"}, 64'(o_scrub_req4), 64'(exp_corr));
    check_counts(tag);
    if (exp_corr) begin
      check_output({tag, " scrub_addr"},  64'(o_scrub_addr),  64'(addr));
      check_output({tag, " scrub_data"},  64'(o_scrub_data),  64'(exp_data));
      check_output({tag, " scrub_addr4"}, 64'(o_scrub_addr4), 64'(addr));
      check_output({tag, " scrub_data4"}, 64'(o_scrub_data4), 64'(exp_data));
      ack_scrub(tag);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    model_corr   = 0;
    model_uncorr = 0;

    vecs[0]  = '{32'h1000, 32'he3a02001, 8'h00, 32'he3a02001, 1'b0, 1'b0};
    vecs[1]  = '{32'h1004, 32'he3a02000, 8'h43, 32'he3a02001, 1'b1, 1'b0};
    vecs[2]  = '{32'h1008, 32'h63a02001, 8'h66, 32'he3a02001, 1'b1, 1'b0};
    vecs[3]  = '{32'h100c, 32'he3a02001, 8'h40, 32'he3a02001, 1'b1, 1'b0};
    vecs[4]  = '{32'h1010, 32'he3a02001, 8'h48, 32'he3a02001, 1'b1, 1'b0};
    vecs[5]  = '{32'h1014, 32'h12345678, 8'h05, 32'h12345678, 1'b0, 1'b1};
    vecs[6]  = '{32'h1018, 32'h12345678, 8'h80, 32'h12345678, 1'b0, 1'b1};
    vecs[7]  = '{32'h101c, 32'h12345678, 8'h7f, 32'h12345678, 1'b0, 1'b1};
    vecs[8]  = '{32'h1020, 32'h00000000, 8'h49, 32'h00000010, 1'b1, 1'b0};
    vecs[9]  = '{32'h1024, 32'h00000000, 8'h51, 32'h00000800, 1'b1, 1'b0};
    vecs[10] = '{32'h1028, 32'hffffffff, 8'h61, 32'hfbffffff, 1'b1, 1'b0};
    vecs[11] = '{32'h102c, 32'ha5a5a5a5, 8'h67, 32'ha5a5a5a5, 1'b0, 1'b1};
    vecs[12] = '{32'h1030, 32'h0f0f0f0f, 8'h60, 32'h0f0f0f0f, 1'b1, 1'b0};
    vecs[13] = '{32'h1034, 32'h0f0f0f0f, 8'h26, 32'h0f0f0f0f, 1'b0, 1'b1};
    vecs[14] = '{32'h1038, 32'h00000000, 8'h47, 32'h00000008, 1'b1, 1'b0};
    vecs[15] = '{32'h103c, 32'h00000000, 8'h4f, 32'h00000400, 1'b1, 1'b0};
    vecs[16] = '{32'h1040, 32'h00000000, 8'h5f, 32'h02000000, 1'b1, 1'b0};

    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_addr      = '0;
    i_data      = '0;
    i_syndrome  = '0;
    i_ready     = 1'b1;
    i_scrub_ack = 1'b0;
    i_count_clr = 1'b0;

    // Reset state.
    #12;
    check_output("reset o_valid",      64'(o_valid),      64'd0);
    check_output("reset o_ready",      64'(o_ready),      64'd1);
    check_output("reset flags", 64'({o_err_corr, o_err_uncorr, o_scrub_req}), 64'd0);
    check_output("reset o_data",       64'(o_data),       64'd0);
    check_output("reset o_addr",       64'(o_addr),       64'd0);
    check_output("reset scrub_addr",   64'(o_scrub_addr), 64'd0);
    check_output("reset scrub_data",   64'(o_scrub_data), 64'd0);
    check_counts("reset");
    i_rst_n = 1'b1;
    step();

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].syn,
                     vecs[i].exp_data, vecs[i].exp_corr, vecs[i].exp_uncorr);
    end

    // Push the correctable count past 15 so the 4-bit copy saturates.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus($sformatf("sat%0d", i), 32'h2000 + 32'(i), 32'he3a02000, 8'h43,
                     32'he3a02001, 1'b1, 1'b0);
    end
    check_output("sat corr_count4 pinned", 64'(o_corr_count4), 64'd15);

    // Clear in the same cycle as an accepted correctable word.
    wait_ready();
    i_addr = 32'h3000; i_data = 32'he3a02000; i_syndrome = 8'h43;
    i_valid = 1'b1; i_count_clr = 1'b1;
    step();
    i_valid = 1'b0; i_count_clr = 1'b0;
    model_corr = 0;
    model_uncorr = 0;
    check_output("clr o_data", 64'(o_data), 64'he3a02001);
    check_counts("clr");
    ack_scrub("clr");

    // Scrub stall: ack withheld 5 cycles while the next word stays valid.
    wait_ready();
    i_addr = 32'h4000; i_data = 32'h63a02001; i_syndrome = 8'h66; i_valid = 1'b1;
    step();
    model_corr++;
    i_addr = 32'h4004; i_data = 32'h55aa55aa; i_syndrome = 8'h00;
    for (int c = 0; c < 5; c++) begin
      check_output($sformatf("stall%0d o_ready", c),   64'(o_ready),      64'd0);
      check_output($sformatf("stall%0d scrub_req", c), 64'(o_scrub_req),  64'd1);
      check_output($sformatf("stall%0d scrub_addr", c), 64'(o_scrub_addr), 64'h4000);
      check_output($sformatf("stall%0d scrub_data", c), 64'(o_scrub_data), 64'he3a02001);
      step();
    end
    i_scrub_ack = 1'b1;
    check_output("stall ack-cycle o_ready", 64'(o_ready), 64'd0);
    step();
    i_scrub_ack = 1'b0;
    check_output("stall o_ready after ack", 64'(o_ready), 64'd1);
    check_output("stall scrub_req after ack", 64'(o_scrub_req), 64'd0);
    step();
    i_valid = 1'b0;
    check_output("stall next o_data", 64'(o_data), 64'h55aa55aa);
    check_output("stall next o_addr", 64'(o_addr), 64'h4004);
    check_counts("stall");

    // Output backpressure then a back-to-back stream.
    step();
    i_ready = 1'b0;
    wait_ready();
    i_addr = 32'h5000; i_data = 32'h11111111; i_syndrome = 8'h00; i_valid = 1'b1;
    step();
    i_addr = 32'h5004; i_data = 32'h22222222;
    for (int c = 0; c < 3; c++) begin
      check_output($sformatf("bp%0d o_valid", c), 64'(o_valid), 64'd1);
      check_output($sformatf("bp%0d o_data", c),  64'(o_data),  64'h11111111);
      check_output($sformatf("bp%0d o_addr", c),  64'(o_addr),  64'h5000);
      check_output($sformatf("bp%0d o_ready", c), 64'(o_ready), 64'd0);
      step();
    end
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_output($sformatf("stream%0d o_valid", c), 64'(o_valid), 64'd1);
      check_output($sformatf("stream%0d o_data", c), 64'(o_data),
                   64'(32'h22222222 * (c + 1)));
      i_data = 32'h22222222 * 32'(c + 2);
      i_addr = 32'h5008 + 32'(4 * c);
    end
    i_valid = 1'b0;
    step();
    check_output("stream drained o_valid", 64'(o_valid), 64'd0);

    // Asynchronous reset while a scrub is pending.
    apply_stimulus("prereset", 32'h6000, 32'he3a02000, 8'h43, 32'he3a02001, 1'b1, 1'b0);
    wait_ready();
    i_addr = 32'h6004; i_data = 32'he3a02000; i_syndrome = 8'h43; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    check_output("pre-rst scrub_req", 64'(o_scrub_req), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_output("async rst scrub_req", 64'(o_scrub_req), 64'd0);
    check_output("async rst o_valid",   64'(o_valid),     64'd0);
    check_output("async rst o_ready",   64'(o_ready),     64'd1);
    check_output("async rst corr_count", 64'(o_corr_count), 64'd0);
    #10;
    i_rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
